// File: rtl/rv32im_lsu_bus.sv
// rv32im_lsu_bus: sequential load/store unit between the EXU memory stage and a
// single-port request/grant/response memory bus. One access in flight at a time.
// Misaligned accesses either fault immediately or become two aligned word beats.
// Opcode encoding (LSU_OPCODE_WIDTH bits): LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7;
// any other code behaves as LW.
`timescale 1ns/1ps

module rv32im_lsu_bus #(
  parameter int ADDR_WIDTH       = 32,
  parameter int MISALIGN_MODE    = 0,
  parameter int TIMEOUT_CYCLES   = 0,
  parameter int LSU_OPCODE_WIDTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
  input  logic [ADDR_WIDTH-1:0]       addr_mem_i,
  input  logic [31:0]                 val_memwr_i,
  output logic                        rsp_valid_o,
  output logic                        rsp_err_o,
  output logic [31:0]                 val_memrd_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [3:0]                  mem_be_o,
  output logic [31:0]                 val_memwr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [31:0]                 val_memrd_i,
  input  logic                        mem_err_i
);

  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LB  = LSU_OPCODE_WIDTH'(0);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LH  = LSU_OPCODE_WIDTH'(1);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LW  = LSU_OPCODE_WIDTH'(2);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LBU = LSU_OPCODE_WIDTH'(3);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LHU = LSU_OPCODE_WIDTH'(4);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SB  = LSU_OPCODE_WIDTH'(5);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SH  = LSU_OPCODE_WIDTH'(6);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SW  = LSU_OPCODE_WIDTH'(7);

  localparam logic        SPLIT_EN   = (MISALIGN_MODE != 0);
  localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LIM     = (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Sign- or zero-extend the selected low byte/half; words pass through.
  function automatic logic [31:0] load_ext(input logic [31:0] v, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      SZ_H:    r = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  state_t                      state_r, state_s;
  logic                        err_s;
  logic [LSU_OPCODE_WIDTH-1:0] op_r;
  logic [ADDR_WIDTH-1:0]       addr_r;
  logic [31:0]                 wdata_r;
  logic [31:0]                 word1_r;
  logic                        split_r;
  logic [15:0]                 cnt_r;

  logic                        req_ready_r, rsp_valid_r, rsp_err_r;
  logic [31:0]                 rdata_r;
  logic                        mem_req_r, mem_we_r;
  logic [ADDR_WIDTH-1:0]       mem_addr_r;
  logic [3:0]                  mem_be_r;
  logic [31:0]                 mem_wdata_r;

  logic [LSU_OPCODE_WIDTH-1:0] cur_op_s;
  logic [ADDR_WIDTH-1:0]       cur_addr_s;
  logic [31:0]                 cur_wdata_s;
  logic [1:0]                  size_s;
  logic                        store_s, uns_s;
  logic [1:0]                  off_s;
  logic [3:0]                  mask_s;
  logic [7:0]                  be64_s;
  logic [63:0]                 data64_s;
  logic                        misal_s;
  logic [ADDR_WIDTH-1:0]       base_s, next_addr_s;
  logic                        timeout_s, accept_s;
  logic [31:0]                 lw_lo_s;
  logic [23:0]                 lw_hi_s;
  logic [31:0]                 sel_s;

  // In IDLE the live request drives lane math so the first beat is ready at accept.
  always_comb begin
    cur_op_s    = op_r;
    cur_addr_s  = addr_r;
    cur_wdata_s = wdata_r;
    if (state_r == S_IDLE) begin
      cur_op_s    = lsu_opcode_i;
      cur_addr_s  = addr_mem_i;
      cur_wdata_s = val_memwr_i;
    end else begin
      cur_op_s    = op_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end
  end

  // Opcode decode into access size, direction and signedness.
  always_comb begin
    size_s  = SZ_W;
    store_s = 1'b0;
    uns_s   = 1'b0;
    case (cur_op_s)
      OP_LB:   size_s = SZ_B;
      OP_LH:   size_s = SZ_H;
      OP_LW:   size_s = SZ_W;
      OP_LBU:  begin size_s = SZ_B; uns_s = 1'b1; end
      OP_LHU:  begin size_s = SZ_H; uns_s = 1'b1; end
      OP_SB:   begin size_s = SZ_B; store_s = 1'b1; end
      OP_SH:   begin size_s = SZ_H; store_s = 1'b1; end
      OP_SW:   begin size_s = SZ_W; store_s = 1'b1; end
      default: size_s = SZ_W;
    endcase
  end

  // Lane placement: byte enables and store data for both possible beats.
  always_comb begin
    off_s = cur_addr_s[1:0];
    case (size_s)
      SZ_B:    begin mask_s = 4'b0001; misal_s = 1'b0; end
      SZ_H:    begin mask_s = 4'b0011; misal_s = off_s[0]; end
      default: begin mask_s = 4'b1111; misal_s = (off_s != 2'b00); end
    endcase
    be64_s      = {4'b0000, mask_s} << off_s;
    data64_s    = {32'd0, cur_wdata_s} << {off_s, 3'b000};
    base_s      = {cur_addr_s[ADDR_WIDTH-1:2], 2'b00};
    next_addr_s = base_s + ADDR_WIDTH'(4);
    timeout_s   = TIMEOUT_EN && (cnt_r == TO_LIM);
    accept_s    = req_valid_i && (state_r == S_IDLE);
  end

  // Merge the two words and pick the addressed bytes; word2 only matters when split.
  always_comb begin
    if (state_r == S_WAIT1) begin
      lw_lo_s = val_memrd_i;
    end else begin
      lw_lo_s = word1_r;
    end
    if (state_r == S_WAIT2) begin
      lw_hi_s = val_memrd_i[23:0];
    end else begin
      lw_hi_s = 24'd0;
    end
    case (off_s)
      2'd0:    sel_s = lw_lo_s;
      2'd1:    sel_s = {lw_hi_s[7:0],  lw_lo_s[31:8]};
      2'd2:    sel_s = {lw_hi_s[15:0], lw_lo_s[31:16]};
      default: sel_s = {lw_hi_s[23:0], lw_lo_s[31:24]};
    endcase
  end

  // Next-state logic and error classification for the response.
  always_comb begin
    state_s = state_r;
    err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid_i) begin
          if (misal_s && !SPLIT_EN) begin
            state_s = S_RESP;
            err_s   = 1'b1;
          end else begin
            state_s = S_REQ1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ1: begin
        if (mem_gnt_i) state_s = S_WAIT1;
        else           state_s = S_REQ1;
      end
      S_WAIT1: begin
        if (mem_rvalid_i) begin
          if (mem_err_i) begin
            state_s = S_RESP;
            err_s   = 1'b1;
          end else if (split_r) begin
            state_s = S_REQ2;
          end else begin
            state_s = S_RESP;
          end
        end else if (timeout_s) begin
          state_s = S_RESP;
          err_s   = 1'b1;
        end else begin
          state_s = S_WAIT1;
        end
      end
      S_REQ2: begin
        if (mem_gnt_i) state_s = S_WAIT2;
        else           state_s = S_REQ2;
      end
      S_WAIT2: begin
        if (mem_rvalid_i) begin
          state_s = S_RESP;
          err_s   = mem_err_i;
        end else if (timeout_s) begin
          state_s = S_RESP;
          err_s   = 1'b1;
        end else begin
          state_s = S_WAIT2;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, captured request, first read word and timeout counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
      op_r    <= '0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      word1_r <= 32'd0;
      split_r <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r    <= lsu_opcode_i;
        addr_r  <= addr_mem_i;
        wdata_r <= val_memwr_i;
        split_r <= misal_s && SPLIT_EN;
      end
      if ((state_r == S_WAIT1) && mem_rvalid_i) begin
        word1_r <= val_memrd_i;
      end
      if (((state_s == S_WAIT1) && (state_r != S_WAIT1)) ||
          ((state_s == S_WAIT2) && (state_r != S_WAIT2))) begin
        cnt_r <= 16'd0;
      end else if ((state_r == S_WAIT1) || (state_r == S_WAIT2)) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= 16'd0;
      end
    end
  end

  // Outputs registered from the next state so they change cleanly with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rdata_r     <= 32'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      req_ready_r <= (state_s == S_IDLE);
      mem_req_r   <= (state_s == S_REQ1) || (state_s == S_REQ2);
      if (state_s == S_REQ1) begin
        mem_we_r    <= store_s;
        mem_addr_r  <= base_s;
        mem_be_r    <= be64_s[3:0];
        mem_wdata_r <= store_s ? data64_s[31:0] : 32'd0;
      end else if (state_s == S_REQ2) begin
        mem_we_r    <= store_s;
        mem_addr_r  <= next_addr_s;
        mem_be_r    <= be64_s[7:4];
        mem_wdata_r <= store_s ? data64_s[63:32] : 32'd0;
      end else begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= '0;
        mem_be_r    <= 4'd0;
        mem_wdata_r <= 32'd0;
      end
      rsp_valid_r <= (state_s == S_RESP);
      rsp_err_r   <= (state_s == S_RESP) && err_s;
      if ((state_s == S_RESP) && !err_s && !store_s) begin
        rdata_r <= load_ext(sel_s, size_s, uns_s);
      end else begin
        rdata_r <= 32'd0;
      end
    end
  end

  assign req_ready_o = req_ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_err_o   = rsp_err_r;
  assign val_memrd_o = rdata_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_be_o    = mem_be_r;
  assign val_memwr_o = mem_wdata_r;

endmodule

// File: tb/tb_rv32im_lsu_bus.sv
// Scoreboard bench for rv32im_lsu_bus: u0 faults on misalignment without timeout,
// u1 splits misaligned accesses and times out after 4 WAIT cycles.
`timescale 1ns/1ps

module tb_rv32im_lsu_bus;

  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4;
  localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7, BAD = 4'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid[2];
  logic [3:0]  opc[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic        gnt[2], rvalid[2], merr[2];
  logic        req_ready[2], rsp_valid[2], rsp_err[2], mem_req[2], mem_we[2];
  logic [31:0] memrd[2], mem_addr[2], mem_wd[2];
  logic [3:0]  mem_be[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rv32im_lsu_bus #(.ADDR_WIDTH(32), .MISALIGN_MODE(0), .TIMEOUT_CYCLES(0), .LSU_OPCODE_WIDTH(4)) u0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .lsu_opcode_i(opc[0]), .addr_mem_i(addr[0]), .val_memwr_i(wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_err_o(rsp_err[0]), .val_memrd_o(memrd[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_be_o(mem_be[0]),
    .val_memwr_o(mem_wd[0]), .mem_gnt_i(gnt[0]), .mem_rvalid_i(rvalid[0]),
    .val_memrd_i(rdata[0]), .mem_err_i(merr[0]));

  rv32im_lsu_bus #(.ADDR_WIDTH(32), .MISALIGN_MODE(1), .TIMEOUT_CYCLES(4), .LSU_OPCODE_WIDTH(4)) u1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .lsu_opcode_i(opc[1]), .addr_mem_i(addr[1]), .val_memwr_i(wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_err_o(rsp_err[1]), .val_memrd_o(memrd[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_be_o(mem_be[1]),
    .val_memwr_o(mem_wd[1]), .mem_gnt_i(gnt[1]), .mem_rvalid_i(rvalid[1]),
    .val_memrd_i(rdata[1]), .mem_err_i(merr[1]));

  typedef struct {int d; logic we; logic [31:0] a; logic [3:0] be; logic [31:0] wd;} beat_t;
  typedef struct {int d; logic err; logic [31:0] data; int cyc;} rsp_t;
  beat_t bq[$];
  rsp_t  rq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares responses and bus beats against the scoreboard queues.
  always @(negedge clk) begin
    rsp_t  e;
    beat_t b;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        if (rq.size() == 0 || rq[0].d != d) begin
          chk($sformatf("unexpected_rsp_u%0d", d), 64'd1, 64'd0);
        end else begin
          e = rq.pop_front();
          chk($sformatf("rsp_err_u%0d", d), {63'd0, rsp_err[d]}, {63'd0, e.err});
          chk($sformatf("rsp_data_u%0d", d), {32'd0, memrd[d]}, {32'd0, e.data});
          if (e.cyc >= 0) chk($sformatf("rsp_latency_u%0d", d), 64'(cyc), 64'(e.cyc));
        end
      end
      if (mem_req[d] === 1'b1) begin
        if (bq.size() == 0 || bq[0].d != d) begin
          chk($sformatf("spurious_req_u%0d", d), 64'd1, 64'd0);
        end else if (gnt[d]) begin
          b = bq.pop_front();
          chk($sformatf("beat_we_be_u%0d", d), {59'd0, mem_we[d], mem_be[d]}, {59'd0, b.we, b.be});
          chk($sformatf("beat_addr_u%0d", d), {32'd0, mem_addr[d]}, {32'd0, b.a});
          chk($sformatf("beat_wdata_u%0d", d), {32'd0, mem_wd[d]}, {32'd0, b.wd});
        end
      end
    end
  end

  task automatic exp_beat(input int d, input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.d = d; b.we = we; b.a = a; b.be = be; b.wd = wd;
    bq.push_back(b);
  endtask

  // One EXU request plus a scripted bus responder; lat<0 skips the latency check.
  task automatic run_op(input int d, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int nb, input logic [31:0] w0,
                        input logic [31:0] w1, input int errb, input int gdel, input bit norv,
                        input logic rerr, input logic [31:0] rdat, input int lat);
    rsp_t e;
    int   t;
    @(posedge clk); #1;
    chk($sformatf("ready_idle_u%0d", d), {63'd0, req_ready[d]}, 64'd1);
    req_valid[d] = 1'b1; opc[d] = op; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    e.d = d; e.err = rerr; e.data = rdat; e.cyc = (lat < 0) ? -1 : cyc + lat;
    rq.push_back(e);
    for (int b = 0; b < nb; b++) begin
      t = 0;
      while (mem_req[d] !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
      if (mem_req[d] !== 1'b1) begin
        chk($sformatf("req_wait_u%0d", d), 64'd0, 64'd1);
        break;
      end
      for (int g = 0; g < gdel; g++) begin
        chk("hold_req", {30'd0, mem_req[d], req_ready[d], mem_addr[d]},
            {30'd0, 1'b1, 1'b0, a & 32'hFFFF_FFFC});
        @(posedge clk); #1;
      end
      gnt[d] = 1'b1;
      @(posedge clk); #1;
      gnt[d] = 1'b0;
      if (norv) break;
      rvalid[d] = 1'b1; rdata[d] = (b == 0) ? w0 : w1; merr[d] = (errb == b);
      @(posedge clk); #1;
      rvalid[d] = 1'b0; merr[d] = 1'b0; rdata[d] = 32'd0;
      if (errb == b) break;
    end
    repeat (8) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; opc[d] = 4'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
      gnt[d] = 1'b0; rvalid[d] = 1'b0; merr[d] = 1'b0; rdata[d] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ctl_u%0d", d),
          {58'd0, req_ready[d], rsp_valid[d], rsp_err[d], mem_req[d], mem_we[d], |mem_be[d]},
          {58'd0, 6'b100000});
      chk($sformatf("reset_data_u%0d", d), {memrd[d] | mem_wd[d], mem_addr[d]}, 64'd0);
    end
    rst = 1'b0;

    // u0: aligned loads/stores, unknown opcode, bus error, misaligned faults
    exp_beat(0, 1'b0, 32'h0, 4'b1111, 32'h0);
    run_op(0, LW, 32'h0, 32'h0, 1, 32'h000CF5BD, 32'h0, -1, 0, 0, 1'b0, 32'h000CF5BD, 2);
    exp_beat(0, 1'b0, 32'h0, 4'b0010, 32'h0);
    run_op(0, LB, 32'h1, 32'h0, 1, 32'h000CF5BD, 32'h0, -1, 0, 0, 1'b0, 32'hFFFFFFF5, 2);
    exp_beat(0, 1'b0, 32'h0, 4'b0010, 32'h0);
    run_op(0, LBU, 32'h1, 32'h0, 1, 32'h000CF5BD, 32'h0, -1, 0, 0, 1'b0, 32'h000000F5, 2);
    exp_beat(0, 1'b0, 32'h0, 4'b1100, 32'h0);
    run_op(0, LH, 32'h2, 32'h0, 1, 32'h80010000, 32'h0, -1, 0, 0, 1'b0, 32'hFFFF8001, 2);
    exp_beat(0, 1'b0, 32'h0, 4'b0011, 32'h0);
    run_op(0, LHU, 32'h0, 32'h0, 1, 32'h000CF5BD, 32'h0, -1, 0, 0, 1'b0, 32'h0000F5BD, 2);
    exp_beat(0, 1'b1, 32'h4, 4'b1100, 32'hABCD0000);
    run_op(0, SH, 32'h6, 32'h1234ABCD, 1, 32'h0, 32'h0, -1, 0, 0, 1'b0, 32'h0, 2);
    exp_beat(0, 1'b1, 32'h0, 4'b1000, 32'hEE000000);
    run_op(0, SB, 32'h3, 32'h000000EE, 1, 32'h0, 32'h0, -1, 0, 0, 1'b0, 32'h0, 2);
    exp_beat(0, 1'b1, 32'h8, 4'b1111, 32'hDEADBEEF);
    run_op(0, SW, 32'h8, 32'hDEADBEEF, 1, 32'h0, 32'h0, -1, 0, 0, 1'b0, 32'h0, 2);
    exp_beat(0, 1'b0, 32'h4, 4'b1111, 32'h0);
    run_op(0, BAD, 32'h4, 32'h0, 1, 32'h89ABCDEF, 32'h0, -1, 0, 0, 1'b0, 32'h89ABCDEF, 2);
    exp_beat(0, 1'b0, 32'h40, 4'b1111, 32'h0);
    run_op(0, LW, 32'h40, 32'h0, 1, 32'h12345678, 32'h0, 0, 0, 0, 1'b1, 32'h0, 2);
    run_op(0, LW, 32'h2, 32'h0, 0, 32'h0, 32'h0, -1, 0, 0, 1'b1, 32'h0, 0);
    run_op(0, SH, 32'h1, 32'h5555, 0, 32'h0, 32'h0, -1, 0, 0, 1'b1, 32'h0, 0);

    // u0: stray rvalid while idle must not produce a response
    @(posedge clk); #1;
    rvalid[0] = 1'b1; rdata[0] = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1; rvalid[0] = 1'b0;
    repeat (3) @(posedge clk);

    // u1: split accesses, address wrap, error on first beat, grant delay, timeout
    exp_beat(1, 1'b1, 32'h0, 4'b1100, 32'hCCDD0000);
    exp_beat(1, 1'b1, 32'h4, 4'b0011, 32'h0000AABB);
    run_op(1, SW, 32'h2, 32'hAABBCCDD, 2, 32'h0, 32'h0, -1, 0, 0, 1'b0, 32'h0, -1);
    exp_beat(1, 1'b0, 32'h0, 4'b1000, 32'h0);
    exp_beat(1, 1'b0, 32'h4, 4'b0111, 32'h0);
    run_op(1, LW, 32'h3, 32'h0, 2, 32'h11223344, 32'h55667788, -1, 0, 0, 1'b0, 32'h66778811, -1);
    exp_beat(1, 1'b0, 32'h0, 4'b1000, 32'h0);
    run_op(1, LW, 32'h3, 32'h0, 2, 32'h11223344, 32'h55667788, 0, 0, 0, 1'b1, 32'h0, -1);
    exp_beat(1, 1'b0, 32'hFFFFFFFC, 4'b1100, 32'h0);
    exp_beat(1, 1'b0, 32'h0, 4'b0011, 32'h0);
    run_op(1, LW, 32'hFFFFFFFE, 32'h0, 2, 32'h56780000, 32'h00001234, -1, 0, 0, 1'b0, 32'h12345678, -1);
    exp_beat(1, 1'b0, 32'h0, 4'b1000, 32'h0);
    exp_beat(1, 1'b0, 32'h4, 4'b0001, 32'h0);
    run_op(1, LH, 32'h3, 32'h0, 2, 32'hAB000000, 32'h000000CD, -1, 0, 0, 1'b0, 32'hFFFFCDAB, -1);
    exp_beat(1, 1'b0, 32'h10, 4'b1111, 32'h0);
    run_op(1, LW, 32'h10, 32'h0, 1, 32'h00000042, 32'h0, -1, 5, 0, 1'b0, 32'h00000042, -1);
    exp_beat(1, 1'b0, 32'h20, 4'b1111, 32'h0);
    run_op(1, LW, 32'h20, 32'h0, 1, 32'h0, 32'h0, -1, 0, 1, 1'b1, 32'h0, -1);

    // u1: reset while waiting for the response; late rvalid is ignored
    exp_beat(1, 1'b0, 32'h30, 4'b1111, 32'h0);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; opc[1] = LW; addr[1] = 32'h30;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; gnt[1] = 1'b1;
    @(posedge clk); #1;
    gnt[1] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_op", {62'd0, mem_req[1], req_ready[1]}, {62'd0, 2'b01});
    rvalid[1] = 1'b1; rdata[1] = 32'h77;
    @(posedge clk); #1;
    rvalid[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
    chk("beat_queue_empty", 64'(bq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
